// File: rtl/i2c_switch_pkg.sv
// i2c_switch_pkg: shared types and constants for the I2C bus switch.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_switch_pkg;

  // Channel-switch sequencing: wait for an idle bus, then apply for one cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } sw_state_t;

  // Largest supported downstream fan-out.
  localparam int MAX_CH = 16;

  // Width of the idle-timeout counter.
  localparam int TMO_W = 16;

endpackage

// File: rtl/i2c_line_filter.sv
// i2c_line_filter: synchronises one asynchronous bus line and suppresses glitches.
// Latency: SYNC_STAGES + FILT_LEN cycles from a clean input edge to line_filt.
// Backpressure: none; free-running sampler.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic line_filt
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   line_s;

  assign line_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, preset to the released (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= line_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Filtered level flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_filt <= 1'b1;
      cnt_q     <= '0;
    end else if (line_s == line_filt) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(FILT_LEN - 1)) begin
      line_filt <= line_s;
      cnt_q     <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bus_switch.sv
// i2c_bus_switch: one upstream open-drain I2C bus to NUM_CH downstream buses; channel changes only while idle.
// Latency: data path combinational; accepted select applies 2 cycles later on an idle bus, else 2 cycles after busy falls.
// Backpressure: sel_ready low while a switch is pending; out-of-range requests dropped with sel_err. I2C_SWITCH_IDLE_TIMEOUT_EN adds idle timeout + timeout_evt.
module i2c_bus_switch
  import i2c_switch_pkg::*;
#(
  parameter  int NUM_CH      = 8,
  parameter  int SYNC_STAGES = 2,
  parameter  int FILT_LEN    = 3,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int SEL_W       = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [SEL_W-1:0]  sel_req,
  input  logic              sel_valid,
  output logic              sel_ready,
  output logic              sel_err,
  output logic [SEL_W-1:0]  active_sel,
  output logic              bus_busy,
  output logic              switch_pending,
  input  logic              up_scl_in,
  input  logic              up_sda_in,
  output logic              up_scl_out,
  output logic              up_sda_out,
  input  logic [NUM_CH-1:0] ch_scl_in,
  input  logic [NUM_CH-1:0] ch_sda_in,
  output logic [NUM_CH-1:0] ch_scl_out,
  output logic [NUM_CH-1:0] ch_sda_out
`ifdef I2C_SWITCH_IDLE_TIMEOUT_EN
  ,
  output logic              timeout_evt
`endif
);

  localparam logic [SEL_W:0] NUM_CH_V = (SEL_W + 1)'(NUM_CH);

  // Reject unsupported configurations at elaboration.
  if (NUM_CH < 2 || NUM_CH > MAX_CH || TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (1 << TMO_W)) begin : g_bad_cfg
    $error("i2c_bus_switch: parameter out of range");
  end

  logic             scl_f, sda_f;
  logic             scl_prev, sda_prev;
  logic             start_det, stop_det;
  logic             tmo_hit;
  logic             req_ok, load_sel, reject;
  logic [SEL_W-1:0] sel_q;
  sw_state_t        state_q, state_d;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk), .reset_n(reset_n), .line_in(up_scl_in), .line_filt(scl_f)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk), .reset_n(reset_n), .line_in(up_sda_in), .line_filt(sda_f)
  );

  // Previous filtered levels for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  // START/STOP: SDA edge while SCL is steadily high.
  assign start_det = scl_f & scl_prev &  sda_prev & ~sda_f;
  assign stop_det  = scl_f & scl_prev & ~sda_prev &  sda_f;

`ifdef I2C_SWITCH_IDLE_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_run;

  // Count only while busy with both lines steadily high; any low or edge restarts.
  assign tmo_run = bus_busy & scl_f & sda_f & scl_prev & sda_prev;
  assign tmo_hit = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Idle-timeout counter and its one-cycle release event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= tmo_hit;
      if (tmo_run && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Bus busy between START and STOP; a repeated START simply keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_busy <= 1'b0;
    end else if (start_det) begin
      bus_busy <= 1'b1;
    end else if (stop_det || tmo_hit) begin
      bus_busy <= 1'b0;
    end
  end

  // Switch FSM next state and handshake decode.
  always_comb begin
    state_d   = state_q;
    sel_ready = (state_q == IDLE);
    req_ok    = ({1'b0, sel_req} < NUM_CH_V);
    load_sel  = 1'b0;
    reject    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          load_sel = req_ok;
          reject   = !req_ok;
          if (req_ok) state_d = PENDING;
        end
      end
      PENDING: begin
        // A START arriving together with idle wins: keep waiting.
        if (!bus_busy && !start_det) state_d = APPLY;
      end
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign switch_pending = (state_q != IDLE);

  // FSM state, latched request, active channel and reject pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      active_sel <= '0;
      sel_err    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_err <= reject;
      if (load_sel) sel_q <= sel_req;
      if (state_q == APPLY) active_sel <= sel_q;
    end
  end

  // Open-drain crossbar: only the active channel is connected; reset releases everything.
  always_comb begin
    ch_scl_out = '1;
    ch_sda_out = '1;
    up_scl_out = 1'b1;
    up_sda_out = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset_n && active_sel == SEL_W'(i)) begin
        ch_scl_out[i] = up_scl_in;
        ch_sda_out[i] = up_sda_in;
        up_scl_out    = ch_scl_in[i];
        up_sda_out    = ch_sda_in[i];
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_switch.sv
// tb_i2c_bus_switch: randomized I2C traffic and select requests against a protocol-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_i2c_bus_switch;

  localparam int NUM_CH = 6;
  localparam int SEL_W  = $clog2(NUM_CH);
  localparam int HOLD   = 6;
  localparam int TMO    = 100;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [SEL_W-1:0]  sel_req;
  logic              sel_valid;
  logic              sel_ready, sel_err, bus_busy, switch_pending;
  logic [SEL_W-1:0]  active_sel;
  logic              up_scl_in, up_sda_in, up_scl_out, up_sda_out;
  logic [NUM_CH-1:0] ch_scl_in, ch_sda_in, ch_scl_out, ch_sda_out;
`ifdef I2C_SWITCH_IDLE_TIMEOUT_EN
  logic              timeout_evt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_active = 0;

  always #5 clk = ~clk;

  i2c_bus_switch #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .FILT_LEN(3), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .sel_req(sel_req), .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_err(sel_err),
    .active_sel(active_sel), .bus_busy(bus_busy), .switch_pending(switch_pending),
    .up_scl_in(up_scl_in), .up_sda_in(up_sda_in), .up_scl_out(up_scl_out), .up_sda_out(up_sda_out),
    .ch_scl_in(ch_scl_in), .ch_sda_in(ch_sda_in), .ch_scl_out(ch_scl_out), .ch_sda_out(ch_sda_out)
`ifdef I2C_SWITCH_IDLE_TIMEOUT_EN
    , .timeout_evt(timeout_evt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Data path rule: active channel mirrors upstream, others released, upstream sees active channel.
  task automatic check_dp(input string tag);
    logic [NUM_CH-1:0] exp_scl, exp_sda;
    exp_scl = '1;
    exp_sda = '1;
    exp_scl[exp_active] = up_scl_in;
    exp_sda[exp_active] = up_sda_in;
    check({tag, "_ch_scl"}, ch_scl_out, exp_scl);
    check({tag, "_ch_sda"}, ch_sda_out, exp_sda);
    check({tag, "_up_scl"}, up_scl_out, ch_scl_in[exp_active]);
    check({tag, "_up_sda"}, up_sda_out, ch_sda_in[exp_active]);
  endtask

  task automatic wait_busy(input logic val, input string tag);
    int k = 0;
    while (bus_busy !== val && k < 40) begin
      tick(1);
      k++;
    end
    check(tag, bus_busy, val);
  endtask

  task automatic start_cond();
    up_scl_in = 1'b1; up_sda_in = 1'b1; tick(HOLD);
    up_sda_in = 1'b0;
    wait_busy(1'b1, "start_busy");
  endtask

  task automatic stop_cond();
    up_scl_in = 1'b0; tick(HOLD);
    up_sda_in = 1'b0; tick(HOLD);
    up_scl_in = 1'b1; tick(HOLD);
    up_sda_in = 1'b1;
    wait_busy(1'b0, "stop_busy");
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [8:0] bits;
    bits = {b, 1'($urandom_range(0, 1))};
    for (int i = 8; i >= 0; i--) begin
      up_scl_in = 1'b0;    tick(HOLD);
      up_sda_in = bits[i]; tick(HOLD);
      up_scl_in = 1'b1;    tick(HOLD);
    end
  endtask

  // Request on an idle bus: bad index -> error pulse, good index -> active two cycles later.
  task automatic request_idle(input int r);
    sel_req = SEL_W'(r); sel_valid = 1'b1;
    check("ready_pre", sel_ready, 1);
    tick(1);
    sel_valid = 1'b0;
    if (r >= NUM_CH) begin
      check("err_pulse", sel_err, 1);
      check("err_pend", switch_pending, 0);
      tick(1);
      check("err_clear", sel_err, 0);
      check("err_active", active_sel, exp_active);
    end else begin
      check("pend_set", switch_pending, 1);
      check("ready_low", sel_ready, 0);
      tick(1);
      check("active_hold", active_sel, exp_active);
      tick(1);
      exp_active = r;
      check("active_apply", active_sel, exp_active);
      check("pend_clear", switch_pending, 0);
      check("ready_back", sel_ready, 1);
      check_dp("idle_dp");
    end
  endtask

  task automatic transfer();
    int r, nb;
    start_cond();
    r = $urandom_range(0, NUM_CH - 1);
    sel_req = SEL_W'(r); sel_valid = 1'b1;
    tick(1);
    sel_valid = 1'b0;
    check("busy_pend", switch_pending, 1);
    nb = $urandom_range(1, 2);
    for (int b = 0; b < nb; b++) begin
      ch_scl_in = NUM_CH'($urandom);
      ch_sda_in = NUM_CH'($urandom);
      send_byte(8'($urandom));
      check("xfer_busy", bus_busy, 1);
      check("xfer_active", active_sel, exp_active);
      check("xfer_pend", switch_pending, 1);
      check_dp("xfer_dp");
      // Not ready: this request must be ignored entirely.
      sel_req = SEL_W'($urandom_range(0, 7)); sel_valid = 1'b1;
      tick(1);
      sel_valid = 1'b0;
      check("ignored_err", sel_err, 0);
      if ($urandom_range(0, 1) == 1) begin
        up_scl_in = 1'b0; tick(HOLD);
        up_sda_in = 1'b1; tick(HOLD);
        up_scl_in = 1'b1; tick(HOLD);
        up_sda_in = 1'b0; tick(HOLD);
        check("rstart_busy", bus_busy, 1);
        check("rstart_active", active_sel, exp_active);
      end
    end
    stop_cond();
    tick(2);
    exp_active = r;
    check("stop_active", active_sel, exp_active);
    check("stop_pend", switch_pending, 0);
  endtask

  task automatic glitch();
    int len;
    len = $urandom_range(1, 3);
    up_scl_in = 1'b1; up_sda_in = 1'b0;
    tick(len);
    up_sda_in = 1'b1;
    if (len < 3) begin
      tick(HOLD + 2);
      check("glitch_busy", bus_busy, 0);
    end else begin
      wait_busy(1'b1, "pulse3_start");
      wait_busy(1'b0, "pulse3_stop");
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; sel_req = '0; sel_valid = 1'b0;
    up_scl_in = 1'b1; up_sda_in = 1'b1;
    ch_scl_in = '0; ch_sda_in = '0;
    #12;
    check("rst_active", active_sel, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_pend", switch_pending, 0);
    check("rst_err", sel_err, 0);
    check("rst_ready", sel_ready, 1);
    check("rst_ch_scl", ch_scl_out, {NUM_CH{1'b1}});
    check("rst_ch_sda", ch_sda_out, {NUM_CH{1'b1}});
    check("rst_up", {up_scl_out, up_sda_out}, 2'b11);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    ch_scl_in = NUM_CH'($urandom); ch_sda_in = NUM_CH'($urandom);
    up_sda_in = 1'b0;
    #1;
    check("first_ch_sda", ch_sda_out, 6'b111110);
    check_dp("first_dp");
    wait_busy(1'b1, "first_start");
    stop_cond();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: request_idle($urandom_range(0, 7));
        1: transfer();
        2: glitch();
        default: begin
          ch_scl_in = NUM_CH'($urandom); ch_sda_in = NUM_CH'($urandom);
          #1;
          check_dp("rand_dp");
          tick(1);
        end
      endcase
    end

`ifdef I2C_SWITCH_IDLE_TIMEOUT_EN
    begin
      int r, k;
      start_cond();
      r = $urandom_range(0, NUM_CH - 1);
      sel_req = SEL_W'(r); sel_valid = 1'b1;
      tick(1);
      sel_valid = 1'b0;
      up_scl_in = 1'b0; tick(HOLD);
      up_sda_in = 1'b1; tick(HOLD);
      up_scl_in = 1'b1;
      k = 0;
      while (timeout_evt !== 1'b1 && k < 300) begin
        tick(1);
        k++;
      end
      check("tmo_evt", timeout_evt, 1);
      check("tmo_busy", bus_busy, 0);
      check("tmo_not_early", k >= TMO, 1);
      tick(1);
      check("tmo_evt_pulse", timeout_evt, 0);
      tick(1);
      exp_active = r;
      check("tmo_active", active_sel, exp_active);
    end
`endif

    // Reset in the middle of a transfer on a non-zero channel.
    request_idle($urandom_range(1, NUM_CH - 1));
    start_cond();
    ch_scl_in = '0; ch_sda_in = '0;
    reset_n = 1'b0;
    #1;
    exp_active = 0;
    check("mid_rst_ch_scl", ch_scl_out, {NUM_CH{1'b1}});
    check("mid_rst_ch_sda", ch_sda_out, {NUM_CH{1'b1}});
    check("mid_rst_up", {up_scl_out, up_sda_out}, 2'b11);
    check("mid_rst_active", active_sel, exp_active);
    check("mid_rst_busy", bus_busy, 0);
    check("mid_rst_ready", sel_ready, 1);
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
